// File: rtl/riscv_pkg.sv
// Shared constants for the integer write-back path.
package riscv_pkg;

  localparam int unsigned XLEN          = 32;
  localparam int unsigned REG_ADDR_W    = 5;
  localparam int unsigned NUM_ARCH_REGS = 32;

  localparam int unsigned DEF_NUM_REQ = 6;
  localparam int unsigned DEF_NUM_WP  = 4;

  // Requester indices; lower index wins at reset.
  localparam int unsigned REQ_ALU0 = 0;
  localparam int unsigned REQ_ALU1 = 1;
  localparam int unsigned REQ_LSU  = 2;
  localparam int unsigned REQ_MUL  = 3;
  localparam int unsigned REQ_DIV  = 4;
  localparam int unsigned REQ_CSR  = 5;

endpackage

// File: rtl/riscv_wb_arbiter_if.sv
// Write-back request bus and register-file write-port bundle.
interface riscv_wb_arbiter_if #(
  parameter int unsigned NUM_REQ = riscv_pkg::DEF_NUM_REQ,
  parameter int unsigned NUM_WP  = riscv_pkg::DEF_NUM_WP,
  parameter int unsigned XLEN    = riscv_pkg::XLEN
);
  import riscv_pkg::*;

  logic [NUM_REQ-1:0]            req_valid_i;
  logic [NUM_REQ*REG_ADDR_W-1:0] req_rd_i;
  logic [NUM_REQ*XLEN-1:0]       req_value_i;
  logic [NUM_REQ-1:0]            req_ready_o;
  logic [NUM_WP-1:0]             wr_en_o;
  logic [NUM_WP*REG_ADDR_W-1:0]  wr_rd_o;
  logic [NUM_WP*XLEN-1:0]        wr_value_o;
  logic [NUM_ARCH_REGS-1:0]      pending_o;
  logic [15:0]                   stall_cnt_o;

  // Requesters / register-file side.
  modport master (
    output req_valid_i, req_rd_i, req_value_i,
    input  req_ready_o, wr_en_o, wr_rd_o, wr_value_o, pending_o, stall_cnt_o
  );

  // Arbiter side.
  modport slave (
    input  req_valid_i, req_rd_i, req_value_i,
    output req_ready_o, wr_en_o, wr_rd_o, wr_value_o, pending_o, stall_cnt_o
  );

endinterface

// File: rtl/riscv_rr_grant.sv
// Combinational rotating-priority scanner: grants up to NUM_WP nonzero-rd
// requests, drops x0 requests for free, and never grants two requests to the
// same destination in one cycle.
module riscv_rr_grant import riscv_pkg::*; #(
  parameter int unsigned NUM_REQ = DEF_NUM_REQ,
  parameter int unsigned NUM_WP  = DEF_NUM_WP,
  localparam int unsigned PtrW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int unsigned PortW  = (NUM_WP > 1) ? $clog2(NUM_WP) : 1,
  localparam int unsigned CntW   = $clog2(NUM_WP + 1)
) (
  input  logic [NUM_REQ-1:0]            valid_i,
  input  logic [NUM_REQ*REG_ADDR_W-1:0] rd_i,
  input  logic [PtrW-1:0]               rr_ptr_i,
  output logic [NUM_REQ-1:0]            ready_o,
  output logic [NUM_WP-1:0]             port_vld_o,
  output logic [NUM_WP-1:0][PtrW-1:0]   port_idx_o,
  output logic [PtrW-1:0]               last_idx_o,
  output logic                          any_grant_o
);

  logic [REG_ADDR_W-1:0] rd_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign rd_arr[g] = rd_i[g*REG_ADDR_W +: REG_ADDR_W];
  end

  // Walk requesters from rr_ptr, wrapping explicitly modulo NUM_REQ.
  always_comb begin
    logic [NUM_ARCH_REGS-1:0] used_rd;
    logic [CntW-1:0]          cnt;
    logic [PtrW-1:0]          idx;
    logic [REG_ADDR_W-1:0]    rd;
    int unsigned              s;
    ready_o     = '0;
    port_vld_o  = '0;
    port_idx_o  = '0;
    last_idx_o  = '0;
    any_grant_o = 1'b0;
    used_rd     = '0;
    cnt         = '0;
    idx         = '0;
    rd          = '0;
    s           = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      s = 32'(rr_ptr_i) + k;
      if (s >= NUM_REQ) s = s - NUM_REQ;
      idx = PtrW'(s);
      rd  = rd_arr[idx];
      if (valid_i[idx]) begin
        if (rd == '0) begin
          ready_o[idx] = 1'b1;
        end else if ((32'(cnt) < NUM_WP) && !used_rd[rd]) begin
          ready_o[idx]                 = 1'b1;
          used_rd[rd]                  = 1'b1;
          port_vld_o[PortW'(cnt)]      = 1'b1;
          port_idx_o[PortW'(cnt)]      = idx;
          cnt                          = cnt + 1'b1;
          last_idx_o                   = idx;
          any_grant_o                  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/riscv_wb_arbiter.sv
// Write-back arbiter: registers granted rd/value pairs onto the register-file
// write ports one cycle after the grant, tracks rotating priority and stalls.
module riscv_wb_arbiter #(
  parameter int unsigned NUM_REQ = riscv_pkg::DEF_NUM_REQ,
  parameter int unsigned NUM_WP  = riscv_pkg::DEF_NUM_WP,
  parameter int unsigned XLEN    = riscv_pkg::XLEN
) (
  input  logic               clk_i,
  input  logic               rst_i,
  riscv_wb_arbiter_if.slave  bus
);
  import riscv_pkg::*;

  localparam int unsigned PtrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [REG_ADDR_W-1:0] req_rd  [NUM_REQ];
  logic [XLEN-1:0]       req_val [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign req_rd[g]  = bus.req_rd_i[g*REG_ADDR_W +: REG_ADDR_W];
    assign req_val[g] = bus.req_value_i[g*XLEN +: XLEN];
  end

  logic [NUM_REQ-1:0]                ready;
  logic [NUM_WP-1:0]                 port_vld;
  logic [NUM_WP-1:0][PtrW-1:0]       port_idx;
  logic [PtrW-1:0]                   last_idx;
  logic                              any_grant;

  logic [PtrW-1:0]                   rr_ptr_q, rr_ptr_d;
  logic [NUM_WP-1:0]                 wr_en_q, wr_en_d;
  logic [NUM_WP-1:0][REG_ADDR_W-1:0] wr_rd_q, wr_rd_d;
  logic [NUM_WP-1:0][XLEN-1:0]       wr_value_q, wr_value_d;
  logic [NUM_ARCH_REGS-1:0]          pending_q, pending_d;
  logic [15:0]                       stall_q, stall_d;
  logic                              stall_hit;

  riscv_rr_grant #(
    .NUM_REQ (NUM_REQ),
    .NUM_WP  (NUM_WP)
  ) u_grant (
    .valid_i     (bus.req_valid_i),
    .rd_i        (bus.req_rd_i),
    .rr_ptr_i    (rr_ptr_q),
    .ready_o     (ready),
    .port_vld_o  (port_vld),
    .port_idx_o  (port_idx),
    .last_idx_o  (last_idx),
    .any_grant_o (any_grant)
  );

  // Route each granted request onto its port; idle ports target x0 with zero data.
  always_comb begin
    wr_en_d    = '0;
    wr_rd_d    = '0;
    wr_value_d = '0;
    pending_d  = '0;
    for (int unsigned p = 0; p < NUM_WP; p++) begin
      if (port_vld[p]) begin
        wr_en_d[p]                  = 1'b1;
        wr_rd_d[p]                  = req_rd[port_idx[p]];
        wr_value_d[p]               = req_val[port_idx[p]];
        pending_d[wr_rd_d[p]]       = 1'b1;
      end
    end
  end

  // Priority moves past the last real grant; x0 drops leave it alone.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (any_grant) begin
      if (32'(last_idx) == NUM_REQ - 1) rr_ptr_d = '0;
      else                              rr_ptr_d = last_idx + 1'b1;
    end
  end

  // A stall cycle has some valid, nonzero-rd request left without ready.
  always_comb begin
    stall_hit = 1'b0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (bus.req_valid_i[j] && (req_rd[j] != '0) && !ready[j]) stall_hit = 1'b1;
    end
    stall_d = (stall_hit && (stall_q != 16'hFFFF)) ? stall_q + 16'd1 : stall_q;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      rr_ptr_q   <= '0;
      wr_en_q    <= '0;
      wr_rd_q    <= '0;
      wr_value_q <= '0;
      pending_q  <= '0;
      stall_q    <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      wr_en_q    <= wr_en_d;
      wr_rd_q    <= wr_rd_d;
      wr_value_q <= wr_value_d;
      pending_q  <= pending_d;
      stall_q    <= stall_d;
    end
  end

  assign bus.req_ready_o = rst_i ? ready : '0;
  assign bus.wr_en_o     = wr_en_q;
  assign bus.wr_rd_o     = wr_rd_q;
  assign bus.wr_value_o  = wr_value_q;
  assign bus.pending_o   = pending_q;
  assign bus.stall_cnt_o = stall_q;

endmodule
